// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
// Sizes match the 16x128 two-port macro.
package sram_fifo_pkg;
  localparam int WIDTH = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 3);

  typedef logic [WIDTH-1:0] buf_entry_t;
endpackage

// File: rtl/sram_fifo_outbuf.sv
// 2-entry output buffer with a bypass from the macro's Q.
// In: clock, reset_n, flush, rd_inflight, sram_q, deq_ready. Out: deq_valid, deq_data, buf_cnt.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             rd_inflight,
  input  logic [WIDTH-1:0] sram_q,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_data,
  output logic [1:0]       buf_cnt
);

  buf_entry_t mem [2];
  logic       head;
  logic       tail;
  logic       has_buf;
  logic       bypass;
  logic       push;
  logic       pop;

  assign has_buf   = (buf_cnt != 2'd0);
  assign deq_valid = has_buf | rd_inflight;
  assign deq_data  = has_buf ? mem[head] : sram_q;

  // Q goes straight out only when the buffer is empty and the consumer takes it.
  assign bypass = !has_buf & rd_inflight & deq_ready;
  assign push   = rd_inflight & !bypass;
  assign pop    = has_buf & deq_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      buf_cnt <= 2'd0;
    end else if (flush) begin
      head    <= 1'b0;
      tail    <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= sram_q;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && !flush && buf_cnt == 2'd2));

  a_q_defined : assert property (
    @(posedge clock) disable iff (!reset_n)
    (deq_valid && !has_buf) |-> rd_inflight);

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of a 16x128 two-port SRAM macro.
// Ports: enq/deq valid-ready, count, flush, and macro WEB/AA/D, REB/AB, Q.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [CW-1:0]    count,
  output logic             sram_web,
  output logic [AW-1:0]    sram_aa,
  output logic [WIDTH-1:0] sram_d,
  output logic             sram_reb,
  output logic [AW-1:0]    sram_ab,
  input  logic [WIDTH-1:0] sram_q
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   sram_cnt;
  logic          rd_inflight;
  logic [1:0]    buf_cnt;
  logic          enq_fire;
  logic          rd_issue;
  logic [2:0]    pend;

  // Not ready while held in reset, so WEB stays high then.
  assign enq_ready = reset_n & (sram_cnt < FULL);
  assign enq_fire  = enq_valid & enq_ready & !flush;

  // Never have more reads outstanding than the buffer can absorb.
  assign pend     = {1'b0, buf_cnt} + {2'b0, rd_inflight};
  assign rd_issue = (sram_cnt != '0) & (pend < 3'd2) & !flush;

  assign sram_web = !enq_fire;
  assign sram_aa  = wr_ptr;
  assign sram_d   = enq_data;
  assign sram_reb = !rd_issue;
  assign sram_ab  = rd_ptr;

  assign count = CW'(sram_cnt) + CW'(rd_inflight) + CW'(buf_cnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      rd_inflight <= rd_issue;
      unique case (1'b1)
        enq_fire && !rd_issue: sram_cnt <= sram_cnt + (AW + 1)'(1);
        rd_issue && !enq_fire: sram_cnt <= sram_cnt - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  sram_fifo_outbuf u_outbuf (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .rd_inflight (rd_inflight),
    .sram_q      (sram_q),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_data    (deq_data),
    .buf_cnt     (buf_cnt)
  );

endmodule
